uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Byte buffer between uart_rx and the byte consumer (LED display, later the command parser).
//  Captures every o_Rx_DV/o_Rx_Byte strobe while the link is enabled.
//  Presents the oldest byte first-word-fall-through and releases it on a one-cycle pop (e.g. debounced button_released).
//  Flushes itself whenever the link is disabled (handshake not successful or failed).
// PARAMETERS
//  DEPTH   16  entries; power of two, >=2; AW = $clog2(DEPTH)
//  DATA_W  8   byte width (uart_pkg::UART_DATA_W)
// PORTS
//  clock        in   1       system clock (50 MHz)
//  reset_n      in   1       asynchronous active-low reset
//  i_Enable     in   1       link enabled (uart_enable); low = synchronous flush
//  i_Rx_DV      in   1       one-cycle strobe from uart_rx: i_Rx_Byte valid
//  i_Rx_Byte    in   DATA_W  received byte
//  i_Pop        in   1       one-cycle request: discard head entry
//  i_Clr_Ovf    in   1       clears sticky overflow flag
//  o_Data       out  DATA_W  head entry (valid when o_Valid), 0 when empty
//  o_Valid      out  1       FIFO not empty
//  o_Full       out  1       count == DEPTH
//  o_Count      out  AW+1    occupied entries, 0..DEPTH
//  o_Overflow   out  1       sticky: a byte was dropped because FIFO was full
// BEHAVIOUR
//  Reset: wr_ptr=rd_ptr=0, count=0. Outputs: o_Valid=0, o_Full=0, o_Count=0, o_Data=0, o_Overflow=0.
//  Storage: DEPTH x DATA_W register array. Pointers are AW bits and wrap DEPTH-1 -> 0 naturally.
//  push = i_Enable & i_Rx_DV; pop = i_Enable & i_Pop & o_Valid. i_Pop while empty is ignored.
//  Push: mem[wr_ptr] <= i_Rx_Byte at the clock edge; the byte is visible on o_Data/o_Valid the next cycle when the FIFO was empty.
//  Pop: rd_ptr advances at the edge; o_Data shows the next entry the following cycle.
//  Data out is combinational from mem[rd_ptr], gated to 0 when empty. No read latency (FWFT).
//  Count updates each edge:
//    push & ~pop: +1
//    pop & ~push: -1
//    both: unchanged
//  Full, push only: byte dropped, pointers/count unchanged, o_Overflow <= 1.
//  Full, push+pop: both accepted, count stays DEPTH, no overflow.
//  Empty, push+pop: pop ignored, push accepted, count -> 1.
//  o_Overflow is sticky. It is cleared by i_Clr_Ovf, by i_Enable=0, or by reset.
//  Set has priority over i_Clr_Ovf in the same cycle.
//  i_Enable=0: pointers, count and o_Overflow clear at the next edge. Memory contents are not cleared.
//  Async reset mid-operation returns to the reset state immediately. Partial data is discarded.
//  o_Full and o_Valid are decoded from count, not from pointer compare.
// CONFIGURATION
//  `UART_RX_FIFO_STATS_EN defined:
//    adds output o_Drop_Cnt [15:0], counting dropped bytes.
//    Saturates at 16'hFFFF. Cleared by reset, i_Enable=0, or i_Clr_Ovf.
//    The clear is ignored in a cycle where a drop occurs, in which case the count increments.
//  Not defined: port absent, no counter logic.
// STRUCTURE
//  uart_pkg (shared): UART_DATA_W=8, UART_CLKS_PER_BIT=5208, typedef logic [UART_DATA_W-1:0] uart_byte_t.
//  Sub-module uart_rx_fifo_mem: register array, one write port, one async read port, no reset on storage.
//  Top level holds pointers, count, flags and the optional stats counter.
// TESTING
//  1 Reset, enable=1, push 8'hA5: next cycle o_Valid=1, o_Data=A5, o_Count=1; pop -> o_Valid=0, o_Data=00.
//  2 Push 16 bytes 00..0F: o_Full=1, o_Count=16. Push 8'hFF -> o_Overflow=1, count=16.
//    Pop all 16: data 00..0F in order. i_Clr_Ovf -> o_Overflow=0.
//  3 Wrap: push 10, pop 10, push 12 (0x20..0x2B), pop 12: order preserved, pointers wrap, count returns to 0.
//  4 Simultaneous: at full, push 8'h77 + pop -> count=16, no overflow, 77 read last.
//    At empty, push 8'h55 + pop -> count=1, o_Data=55.
//  5 Flush: fill 5 entries, drop i_Enable one cycle: count=0, o_Valid=0, o_Overflow=0.
//    i_Rx_DV while disabled is not stored.
//  6 Async reset asserted mid-burst (count=7): outputs are reset-valued immediately.
//    With STATS_EN, 3 drops -> o_Drop_Cnt=3, then reset -> 0.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants and types used by the receive FIFO and its neighbours.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 5208;
    localparam int FIFO_DEPTH        = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_rx_fifo_if.sv
// Producer/consumer-facing signal bundle of the UART receive FIFO.
// o_Drop_Cnt exists only when UART_RX_FIFO_STATS_EN is defined.
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 4
);
    logic              i_Enable;
    logic              i_Rx_DV;
    logic [DATA_W-1:0] i_Rx_Byte;
    logic              i_Pop;
    logic              i_Clr_Ovf;
    logic [DATA_W-1:0] o_Data;
    logic              o_Valid;
    logic              o_Full;
    logic [AW:0]       o_Count;
    logic              o_Overflow;
`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0]       o_Drop_Cnt;
`endif

    modport slave (
        input  i_Enable, i_Rx_DV, i_Rx_Byte, i_Pop, i_Clr_Ovf,
`ifdef UART_RX_FIFO_STATS_EN
        output o_Drop_Cnt,
`endif
        output o_Data, o_Valid, o_Full, o_Count, o_Overflow
    );

    modport master (
        output i_Enable, i_Rx_DV, i_Rx_Byte, i_Pop, i_Clr_Ovf,
`ifdef UART_RX_FIFO_STATS_EN
        input  o_Drop_Cnt,
`endif
        input  o_Data, o_Valid, o_Full, o_Count, o_Overflow
    );

endinterface : uart_rx_fifo_if

// File: rtl/uart_rx_fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module uart_rx_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage write
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : uart_rx_fifo_mem

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte buffer between uart_rx and the byte consumer.
// Optional drop statistics counter enabled by `UART_RX_FIFO_STATS_EN.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic          clock,
    input  logic          reset_n,
    uart_rx_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              empty_s, full_s;
    logic              push_s, pop_s, accept_s, drop_s;
    logic [DATA_W-1:0] rdata_s;

    assign empty_s  = (count_q == {(AW+1){1'b0}});
    assign full_s   = (count_q == (AW+1)'(DEPTH));
    assign push_s   = bus.i_Enable & bus.i_Rx_DV;
    assign pop_s    = bus.i_Enable & bus.i_Pop & ~empty_s;
    // A full FIFO still takes a byte when the head leaves in the same cycle
    assign accept_s = push_s & (~full_s | pop_s);
    assign drop_s   = push_s & full_s & ~pop_s;

    uart_rx_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clock   (clock),
        .we_i    (accept_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.i_Rx_Byte),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_s)
    );

    // Next-state for pointers, occupancy and sticky overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (!bus.i_Enable) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW+1){1'b0}};
            ovf_d    = 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({accept_s, pop_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            if (drop_s) begin
                ovf_d = 1'b1;
            end else if (bus.i_Clr_Ovf) begin
                ovf_d = 1'b0;
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // Pointer, count and flag state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.o_Data     = empty_s ? {DATA_W{1'b0}} : rdata_s;
    assign bus.o_Valid    = ~empty_s;
    assign bus.o_Full     = full_s;
    assign bus.o_Count    = count_q;
    assign bus.o_Overflow = ovf_q;

`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating drop counter; a drop outranks a same-cycle clear
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (!bus.i_Enable) begin
            drop_cnt_d = 16'h0000;
        end else if (drop_s) begin
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'h0001;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else if (bus.i_Clr_Ovf) begin
            drop_cnt_d = 16'h0000;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= 16'h0000;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.o_Drop_Cnt = drop_cnt_q;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized
// run compared each cycle against a queue-based model of the FIFO.
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    localparam int DEPTH = FIFO_DEPTH;

    logic clock;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   cmp_en   = 1'b0;

    uart_rx_fifo_if #(.DATA_W(UART_DATA_W), .AW($clog2(DEPTH))) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(UART_DATA_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a plain queue of accepted bytes plus flag/counter
    uart_byte_t mq[$];
    bit         m_ovf;
    int         m_drop;

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n || !bus.i_Enable) begin
                mq.delete();
                m_ovf  = 1'b0;
                m_drop = 0;
            end else begin
                bit do_pop;
                do_pop = bus.i_Pop && (mq.size() > 0);
                if (bus.i_Rx_DV && mq.size() == DEPTH && !do_pop) begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop = m_drop + 1;
                end else begin
                    if (do_pop) void'(mq.pop_front());
                    if (bus.i_Rx_DV) mq.push_back(bus.i_Rx_Byte);
                    if (bus.i_Clr_Ovf) begin
                        m_ovf  = 1'b0;
                        m_drop = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clock);
            if (cmp_en) begin
                chk("m_valid", 32'(bus.o_Valid), 32'(mq.size() != 0));
                chk("m_count", 32'(bus.o_Count), 32'(mq.size()));
                chk("m_full",  32'(bus.o_Full),  32'(mq.size() == DEPTH));
                chk("m_data",  32'(bus.o_Data),  (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
                chk("m_ovf",   32'(bus.o_Overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_STATS_EN
                chk("m_drop",  32'(bus.o_Drop_Cnt), 32'(m_drop));
`endif
            end
        end
    end

    // Apply one cycle of inputs; returns just after the following falling edge
    task automatic step(input bit en, input bit dv, input logic [7:0] b, input bit pop, input bit clr);
        bus.i_Enable  = en;
        bus.i_Rx_DV   = dv;
        bus.i_Rx_Byte = b;
        bus.i_Pop     = pop;
        bus.i_Clr_Ovf = clr;
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.i_Enable  = 1'b0;
        bus.i_Rx_DV   = 1'b0;
        bus.i_Rx_Byte = 8'h00;
        bus.i_Pop     = 1'b0;
        bus.i_Clr_Ovf = 1'b0;
        reset_n       = 1'b0;
        @(negedge clock);
        #1;
        chk("rst_valid", 32'(bus.o_Valid), 32'h0);
        chk("rst_count", 32'(bus.o_Count), 32'h0);
        chk("rst_full",  32'(bus.o_Full),  32'h0);
        chk("rst_data",  32'(bus.o_Data),  32'h0);
        chk("rst_ovf",   32'(bus.o_Overflow), 32'h0);
        apply_reset();
        cmp_en = 1'b1;

        // Single byte in and out
        step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        chk("t1_valid", 32'(bus.o_Valid), 32'h1);
        chk("t1_data",  32'(bus.o_Data),  32'hA5);
        chk("t1_count", 32'(bus.o_Count), 32'h1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_pop_valid", 32'(bus.o_Valid), 32'h0);
        chk("t1_pop_data",  32'(bus.o_Data),  32'h0);

        // Fill, overflow, drain in order, clear overflow
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
        chk("t2_full",  32'(bus.o_Full),  32'h1);
        chk("t2_count", 32'(bus.o_Count), 32'd16);
        step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        chk("t2_ovf",       32'(bus.o_Overflow), 32'h1);
        chk("t2_ovf_count", 32'(bus.o_Count),    32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_order", 32'(bus.o_Data), 32'(i));
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("t2_ovf_held", 32'(bus.o_Overflow), 32'h1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("t2_ovf_clr", 32'(bus.o_Overflow), 32'h0);

        // Pointer wrap
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("t3_order_a", 32'(bus.o_Data), 32'(8'h10 + i));
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        chk("t3_count12", 32'(bus.o_Count), 32'd12);
        for (int i = 0; i < 12; i++) begin
            chk("t3_order_b", 32'(bus.o_Data), 32'(8'h20 + i));
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("t3_count0", 32'(bus.o_Count), 32'h0);

        // Simultaneous push and pop at full, then at empty
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        chk("t4_full_count", 32'(bus.o_Count),    32'd16);
        chk("t4_full_ovf",   32'(bus.o_Overflow), 32'h0);
        for (int i = 0; i < 16; i++) begin
            chk("t4_order", 32'(bus.o_Data), (i == 15) ? 32'h77 : 32'(8'h61 + i));
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
        chk("t4_empty_count", 32'(bus.o_Count), 32'h1);
        chk("t4_empty_data",  32'(bus.o_Data),  32'h55);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // Flush by disabling the link
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_count5", 32'(bus.o_Count),    32'd5);
        chk("t5_ovf_pre", 32'(bus.o_Overflow), 32'h1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5_count", 32'(bus.o_Count),    32'h0);
        chk("t5_valid", 32'(bus.o_Valid),    32'h0);
        chk("t5_ovf",   32'(bus.o_Overflow), 32'h0);
        step(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5_nostore", 32'(bus.o_Count), 32'h0);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        chk("t6_count7", 32'(bus.o_Count), 32'd7);
        #6;
        reset_n = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.o_Valid), 32'h0);
        chk("t6_count", 32'(bus.o_Count), 32'h0);
        chk("t6_data",  32'(bus.o_Data),  32'h0);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
`ifdef UART_RX_FIFO_STATS_EN
        for (int i = 0; i < 19; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
        chk("t6_drop3", 32'(bus.o_Drop_Cnt), 32'd3);
        #6;
        reset_n = 1'b0;
        #1;
        chk("t6_drop_rst", 32'(bus.o_Drop_Cnt), 32'h0);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
`endif

        // Randomized traffic with alternating fill-heavy and drain-heavy phases
        for (int c = 0; c < 4000; c++) begin
            int p_push, p_pop;
            p_push = ((c / 400) % 2 == 1) ? 85 : 35;
            p_pop  = ((c / 400) % 2 == 1) ? 30 : 70;
            step($urandom_range(99) >= 2,
                 $urandom_range(99) < p_push,
                 8'($urandom_range(255)),
                 $urandom_range(99) < p_pop,
                 $urandom_range(15) == 0);
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_fifo
